// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the serial receive front end.
//   rx_state_t        receiver FSM states
//   CHAR_W            width of one received character
//   DEF_CLKS_PER_BIT  default oversampling ratio (clk cycles per serial bit)
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam int CHAR_W           = 8;
   localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/char_fifo.sv
// ---------------------------------------------------------------------------
// char_fifo
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on pop_data, so a consumer can look at it before deciding to pop.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; empties the FIFO, clears storage
//   push       write push_data this cycle (ignored when full without a pop)
//   push_data  entry to write
//   pop        remove the head entry this cycle (ignored when empty)
//   pop_data   head entry
//   full       DEPTH entries held
//   empty      no entries held
//   count      number of entries held (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module char_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is still accepted when the head leaves in the
   // same cycle; when full, wr_ptr equals rd_ptr, so the new entry simply
   // takes the slot being vacated and lands at the tail.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   // Storage, pointers and occupancy. Storage is cleared on reset so the
   // head output reads zero out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_char_rx.sv
// ---------------------------------------------------------------------------
// uart_char_rx
// Serial front end of the text-checking path. Receives 8N1 UART frames
// (optionally with an even-parity bit) on rxd, buffers good characters in a
// small FWFT FIFO and hands them out one per valid/ready handshake.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; aborts any frame, flushes the FIFO
//   rxd        serial input, idle high, asynchronous to clk
//   out_data   head-of-FIFO character
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts out_data this cycle
//   frame_err  1-cycle pulse: bad stop bit or bad parity, byte dropped
//   overrun    1-cycle pulse: good byte dropped because the FIFO was full
//   busy       receiver FSM not in IDLE (registered)
// ---------------------------------------------------------------------------
module uart_char_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4,
   parameter int PARITY_EN    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rxd,
   output logic [CHAR_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              frame_err,
   output logic              overrun,
   output logic              busy
);

   localparam int                CW      = $clog2(CLKS_PER_BIT);
   localparam int                FCW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0]     HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]     FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic              sync1;
   logic              rxs;

   rx_state_t         state;
   rx_state_t         state_n;
   logic [CW-1:0]     bit_cnt;
   logic [CW-1:0]     bit_cnt_n;
   logic [2:0]        bit_idx;
   logic [2:0]        bit_idx_n;
   logic [CHAR_W-1:0] shreg;
   logic [CHAR_W-1:0] shreg_n;
   logic              parity_bad;
   logic              parity_bad_n;
   logic              push;
   logic              ferr_n;

   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCW-1:0]    fifo_count;

   // Two-flop synchronizer for the asynchronous serial line. Both flops
   // reset to the idle (high) level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= rxd;
         rxs   <= sync1;
      end
   end

   // Receiver state, bit timing and shift register. busy mirrors the next
   // state so it equals (state != IDLE) without a combinational path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         parity_bad <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         bit_idx    <= bit_idx_n;
         shreg      <= shreg_n;
         parity_bad <= parity_bad_n;
         frame_err  <= ferr_n;
         overrun    <= push && fifo_full && !fifo_pop;
         busy       <= (state_n != IDLE);
      end
   end

   // Next-state logic. The start bit is re-checked at its midpoint to reject
   // glitches; from then on every sample lands one full bit time later, i.e.
   // near the middle of each following bit. The stop sample always returns
   // to IDLE so a new start edge can be caught in the second half of the
   // stop bit.
   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt + CW'(1);
      bit_idx_n    = bit_idx;
      shreg_n      = shreg;
      parity_bad_n = parity_bad;
      push         = 1'b0;
      ferr_n       = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            if (!rxs) begin
               state_n = START;
            end
         end
         START: begin
            if (bit_cnt == HALF_M1) begin
               bit_cnt_n = '0;
               if (rxs) begin
                  state_n = IDLE;
               end else begin
                  state_n      = DATA;
                  bit_idx_n    = '0;
                  parity_bad_n = 1'b0;
               end
            end
         end
         DATA: begin
            if (bit_cnt == FULL_M1) begin
               bit_cnt_n = '0;
               shreg_n   = {rxs, shreg[CHAR_W-1:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
               end
            end
         end
         PARITY: begin
            if (bit_cnt == FULL_M1) begin
               bit_cnt_n    = '0;
               parity_bad_n = ^{shreg, rxs};
               state_n      = STOP;
            end
         end
         STOP: begin
            if (bit_cnt == FULL_M1) begin
               bit_cnt_n = '0;
               state_n   = IDLE;
               if (!rxs || parity_bad) begin
                  ferr_n = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end
         end
         default: begin
            state_n   = IDLE;
            bit_cnt_n = '0;
         end
      endcase
   end

   // The head leaves whenever the consumer takes it while the FIFO holds
   // something.
   assign fifo_pop  = out_ready && (fifo_count != '0);
   assign out_valid = !fifo_empty;

   char_fifo #(
      .WIDTH (CHAR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (shreg),
      .pop       (fifo_pop),
      .pop_data  (out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_uart_char_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_char_rx
// Scoreboard bench for uart_char_rx. Two instances: dut (no parity) and
// dutp (even parity). Stimulus pushes the characters it expects into a
// queue; a monitor pops and compares whenever a handshake completes, and
// also counts error pulses and checks head stability while stalled.
// ---------------------------------------------------------------------------
module tb_uart_char_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       rxd_p = 1'b1;
   logic       out_ready = 1'b1;
   logic       out_ready_p = 1'b1;

   logic [7:0] out_data, out_data_p;
   logic       out_valid, out_valid_p;
   logic       frame_err, frame_err_p;
   logic       overrun, overrun_p;
   logic       busy, busy_p;

   int         vectors = 0;
   int         miscompares = 0;
   int         cyc = 0;
   int         start_cyc = 0;
   int         first_valid_cyc = -1;
   bit         lat_armed = 1'b0;

   logic [7:0] expq[$];
   logic [7:0] expq_p[$];

   int         fe_cnt = 0, ov_cnt = 0, fe_cnt_p = 0, ov_cnt_p = 0;
   int         valid_cycles = 0, valid_cycles_p = 0;

   logic       prev_valid = 1'b0, prev_ready = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic       prev_fe = 1'b0, prev_ov = 1'b0, prev_fe_p = 1'b0;

   uart_char_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4),
      .PARITY_EN    (0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   uart_char_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4),
      .PARITY_EN    (1)
   ) dutp (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd_p),
      .out_data  (out_data_p),
      .out_valid (out_valid_p),
      .out_ready (out_ready_p),
      .frame_err (frame_err_p),
      .overrun   (overrun_p),
      .busy      (busy_p)
   );

   // 100 MHz clock and a free-running cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset) begin
         prev_valid = 1'b0;
         prev_fe    = 1'b0;
         prev_ov    = 1'b0;
         prev_fe_p  = 1'b0;
      end else begin
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_out: got %02h, expected no output", out_data);
            end else begin
               checkOutput("rx_data", out_data, expq.pop_front());
            end
         end
         if (prev_valid && !prev_ready && out_valid)
            checkOutput("hold_stable", out_data, prev_data);
         if (lat_armed && out_valid && first_valid_cyc < 0)
            first_valid_cyc = cyc;
         if (frame_err) fe_cnt++;
         if (overrun) ov_cnt++;
         if (frame_err && prev_fe)
            checkOutput("frame_err_width", 2, 1);
         if (overrun && prev_ov)
            checkOutput("overrun_width", 2, 1);
         if (frame_err && overrun)
            checkOutput("err_exclusive", 1, 0);

         if (out_valid_p) valid_cycles_p++;
         if (out_valid_p && out_ready_p) begin
            if (expq_p.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected_out_p: got %02h, expected no output", out_data_p);
            end else begin
               checkOutput("rx_data_p", out_data_p, expq_p.pop_front());
            end
         end
         if (frame_err_p) fe_cnt_p++;
         if (overrun_p) ov_cnt_p++;
         if (frame_err_p && prev_fe_p)
            checkOutput("frame_err_p_width", 2, 1);

         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_fe    = frame_err;
         prev_ov    = overrun;
         prev_fe_p  = frame_err_p;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic driveLine(input bit sel, input logic v, input int len);
      if (sel) rxd_p = v;
      else     rxd   = v;
      waitCycles(len);
   endtask

   // One serial frame: start, 8 data bits LSB first, optional parity bit
   // (par < 0 means none), stop. A bad stop bit is held low only past the
   // receiver's sample point so it is not mistaken for a new start bit.
   task automatic applyStimulus(input bit sel, input logic [7:0] d,
                                input int par, input bit good_stop);
      start_cyc = cyc;
      driveLine(sel, 1'b0, CPB);
      for (int i = 0; i < 8; i++) driveLine(sel, d[i], CPB);
      if (par >= 0) driveLine(sel, par[0], CPB);
      if (good_stop) begin
         driveLine(sel, 1'b1, CPB);
      end else begin
         driveLine(sel, 1'b0, 12);
         driveLine(sel, 1'b1, 4);
      end
   endtask

   initial begin
      #1_000_000;
      miscompares++;
      $display("[TB] FAIL timeout: simulation exceeded time budget");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int        g, fe0, ov0, vc0;
      logic [7:0] word [5];
      word[0] = 8'h62; word[1] = 8'h65; word[2] = 8'h67;
      word[3] = 8'h69; word[4] = 8'h6E;

      // Reset state, then a long idle line.
      reset = 1'b1;
      waitCycles(3);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_out_data", out_data, 8'h00);
      checkOutput("rst_frame_err", frame_err, 0);
      checkOutput("rst_overrun", overrun, 0);
      reset = 1'b0;
      waitCycles(200);
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_fe_cnt", fe_cnt, 0);
      checkOutput("idle_ov_cnt", ov_cnt, 0);
      checkOutput("idle_valid_p", out_valid_p, 0);

      // Single character 'b' with latency check.
      $display("[TB] single character");
      out_ready = 1'b1;
      first_valid_cyc = -1;
      lat_armed = 1'b1;
      vc0 = valid_cycles;
      expq.push_back(8'h62);
      applyStimulus(1'b0, 8'h62, -1, 1'b1);
      waitCycles(20);
      lat_armed = 1'b0;
      checkOutput("b_latency", first_valid_cyc - start_cyc, 155);
      checkOutput("b_valid_cycles", valid_cycles - vc0, 1);
      checkOutput("b_delivered", expq.size(), 0);
      checkOutput("b_busy_after", busy, 0);

      // Short low glitch: rejected at the start-bit midpoint.
      $display("[TB] start glitch");
      fe0 = fe_cnt;
      vc0 = valid_cycles;
      g = cyc;
      driveLine(1'b0, 1'b0, 4);
      driveLine(1'b0, 1'b1, 2);
      checkOutput("glitch_busy_high", busy, 1);
      waitCycles(6);
      checkOutput("glitch_cycle", cyc - g, 12);
      checkOutput("glitch_busy_low", busy, 0);
      waitCycles(20);
      checkOutput("glitch_no_fe", fe_cnt - fe0, 0);
      checkOutput("glitch_no_out", valid_cycles - vc0, 0);

      // Bad stop bit, then a good frame.
      $display("[TB] framing error");
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      vc0 = valid_cycles;
      applyStimulus(1'b0, 8'h20, -1, 1'b0);
      waitCycles(30);
      checkOutput("ferr_pulse", fe_cnt - fe0, 1);
      checkOutput("ferr_no_ov", ov_cnt - ov0, 0);
      checkOutput("ferr_no_out", valid_cycles - vc0, 0);
      checkOutput("ferr_busy", busy, 0);
      expq.push_back(8'h41);
      applyStimulus(1'b0, 8'h41, -1, 1'b1);
      waitCycles(20);
      checkOutput("after_ferr_delivered", expq.size(), 0);
      checkOutput("after_ferr_fe", fe_cnt - fe0, 1);

      // "begin" back-to-back with the consumer stalled: 'n' overruns.
      $display("[TB] overrun");
      out_ready = 1'b0;
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) expq.push_back(word[i]);
         applyStimulus(1'b0, word[i], -1, 1'b1);
      end
      waitCycles(30);
      checkOutput("ovr_pulse", ov_cnt - ov0, 1);
      checkOutput("ovr_no_fe", fe_cnt - fe0, 0);
      checkOutput("ovr_valid", out_valid, 1);
      checkOutput("ovr_head", out_data, 8'h62);
      out_ready = 1'b1;
      waitCycles(8);
      checkOutput("drain_all", expq.size(), 0);
      checkOutput("drain_valid_low", out_valid, 0);

      // Reset in the middle of a data bit with two characters queued.
      $display("[TB] reset mid-frame");
      out_ready = 1'b0;
      expq.push_back(8'h78);
      applyStimulus(1'b0, 8'h78, -1, 1'b1);
      expq.push_back(8'h79);
      applyStimulus(1'b0, 8'h79, -1, 1'b1);
      waitCycles(5);
      checkOutput("preq_valid", out_valid, 1);
      driveLine(1'b0, 1'b0, CPB);
      driveLine(1'b0, 1'b1, 20);
      checkOutput("mid_data_busy", busy, 1);
      reset = 1'b1;
      waitCycles(2);
      expq.delete();
      checkOutput("midrst_valid", out_valid, 0);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_data", out_data, 8'h00);
      reset = 1'b0;
      waitCycles(30);
      checkOutput("postrst_valid", out_valid, 0);
      checkOutput("postrst_busy", busy, 0);
      out_ready = 1'b1;
      expq.push_back(8'h7A);
      applyStimulus(1'b0, 8'h7A, -1, 1'b1);
      waitCycles(20);
      checkOutput("postrst_delivered", expq.size(), 0);

      // Even parity on dutp: 0x45 has three ones, so the good parity bit is 1.
      $display("[TB] parity");
      fe0 = fe_cnt_p;
      vc0 = valid_cycles_p;
      applyStimulus(1'b1, 8'h45, 0, 1'b1);
      waitCycles(20);
      checkOutput("par45_bad_fe", fe_cnt_p - fe0, 1);
      checkOutput("par45_bad_no_out", valid_cycles_p - vc0, 0);
      expq_p.push_back(8'h45);
      applyStimulus(1'b1, 8'h45, 1, 1'b1);
      waitCycles(20);
      checkOutput("par45_good_out", expq_p.size(), 0);
      checkOutput("par45_good_fe", fe_cnt_p - fe0, 1);
      expq_p.push_back(8'h41);
      applyStimulus(1'b1, 8'h41, 0, 1'b1);
      waitCycles(20);
      checkOutput("par41_good_out", expq_p.size(), 0);
      applyStimulus(1'b1, 8'h41, 1, 1'b1);
      waitCycles(20);
      checkOutput("par41_bad_fe", fe_cnt_p - fe0, 2);
      checkOutput("par_ov_none", ov_cnt_p, 0);
      checkOutput("par_busy", busy_p, 0);

      checkOutput("final_queue", expq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
